// File: rtl/dca_matrix_reorder_unit_multimode_if.sv
// Bundle of control, instruction-FIFO, LSU load and LSU store signals of the
// matrix reorder unit. The master side drives the unit, the slave side is the unit.
interface dca_matrix_reorder_unit_multimode_if #(
  parameter int MATRIX_SIZE = 8,
  parameter int BW_SCALAR   = 16,
  parameter int BW_IDX      = $clog2(MATRIX_SIZE),
  parameter int BW_INST     = 2 + 2 * BW_IDX
);
  logic                            clear_request;
  logic                            clear_finish;
  logic                            inst_fifo_rready;
  logic [BW_INST-1:0]              inst_fifo_rdata;
  logic                            inst_fifo_rrequest;
  logic                            operation_finish;
  logic [3:0]                      core_status;
  logic                            sload_row_wvalid;
  logic                            sload_row_wlast;
  logic [BW_SCALAR*MATRIX_SIZE-1:0] sload_row_wdata;
  logic                            sload_row_wready;
  logic                            sstore_row_rvalid;
  logic                            sstore_row_rready;
  logic                            sstore_row_rlast;
  logic [BW_SCALAR*MATRIX_SIZE-1:0] sstore_row_rdata;

  modport master (
    output clear_request, inst_fifo_rready, inst_fifo_rdata,
    output sload_row_wvalid, sload_row_wlast, sload_row_wdata,
    output sstore_row_rvalid, sstore_row_rlast,
    input  clear_finish, inst_fifo_rrequest, operation_finish, core_status,
    input  sload_row_wready, sstore_row_rready, sstore_row_rdata
  );

  modport slave (
    input  clear_request, inst_fifo_rready, inst_fifo_rdata,
    input  sload_row_wvalid, sload_row_wlast, sload_row_wdata,
    input  sstore_row_rvalid, sstore_row_rlast,
    output clear_finish, inst_fifo_rrequest, operation_finish, core_status,
    output sload_row_wready, sstore_row_rready, sstore_row_rdata
  );
endinterface

// File: rtl/dca_matrix_reorder_unit_multimode.sv
// Buffers one N x N matrix row by row and re-emits it as copy, transpose,
// row-reverse or column-reverse, one instruction at a time.
module dca_matrix_reorder_unit_multimode #(
  parameter int MATRIX_SIZE = 8,
  parameter int BW_SCALAR   = 16
) (
  input  logic clk,
  input  logic rstnn,
  dca_matrix_reorder_unit_multimode_if.slave bus
);
  localparam int N       = MATRIX_SIZE;
  localparam int BW_IDX  = $clog2(MATRIX_SIZE);
  localparam int BW_INST = 2 + 2 * BW_IDX;
  localparam int BW_ROW  = BW_SCALAR * N;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [BW_IDX-1:0]   r_row_m1;
  logic [BW_IDX-1:0]   r_col_m1;
  logic [BW_IDX-1:0]   r_row_cnt;
  logic [BW_IDX-1:0]   r_out_cnt;
  logic                r_size_error;
  logic                r_clear_finish;
  logic [BW_ROW-1:0]   r_buf [0:N-1];

  logic [1:0]          w_inst_mode;
  logic [BW_IDX-1:0]   w_inst_row_m1;
  logic [BW_IDX-1:0]   w_inst_col_m1;
  logic [BW_IDX-1:0]   w_or_m1;
  logic                w_pop;
  logic                w_row_last;
  logic [BW_ROW-1:0]   w_load_row;
  logic [BW_ROW-1:0]   w_rdata;

  assign w_inst_mode   = bus.inst_fifo_rdata[BW_INST-1 -: 2];
  assign w_inst_row_m1 = bus.inst_fifo_rdata[2*BW_IDX-1 -: BW_IDX];
  assign w_inst_col_m1 = bus.inst_fifo_rdata[BW_IDX-1:0];
  assign w_or_m1       = (r_mode == 2'd1) ? r_col_m1 : r_row_m1;
  assign w_row_last    = (r_row_cnt == r_row_m1);
  assign w_pop         = (r_state == S_IDLE) && bus.inst_fifo_rready && !bus.clear_request;

  assign bus.inst_fifo_rrequest = w_pop;
  assign bus.sload_row_wready   = (r_state == S_LOAD);
  assign bus.sstore_row_rready  = (r_state == S_STORE) && bus.sstore_row_rvalid &&
                                  !bus.clear_request && (r_out_cnt <= w_or_m1);
  assign bus.sstore_row_rdata   = w_rdata;
  assign bus.operation_finish   = (r_state == S_DONE) && !bus.clear_request;
  assign bus.clear_finish       = r_clear_finish;
  assign bus.core_status        = {r_size_error, (r_state != S_IDLE), r_state};

  // Incoming row with columns beyond the instruction width forced to zero
  always_comb begin
    w_load_row = '0;
    for (int j = 0; j < N; j++) begin
      if (BW_IDX'(j) <= r_col_m1) begin
        w_load_row[j*BW_SCALAR +: BW_SCALAR] = bus.sload_row_wdata[j*BW_SCALAR +: BW_SCALAR];
      end else begin
        w_load_row[j*BW_SCALAR +: BW_SCALAR] = '0;
      end
    end
  end

  // Output row selection; out_cnt never exceeds the last output row, so no index wraps
  always_comb begin
    w_rdata = '0;
    for (int j = 0; j < N; j++) begin
      case (r_mode)
        2'd0: w_rdata[j*BW_SCALAR +: BW_SCALAR] = r_buf[r_out_cnt][j*BW_SCALAR +: BW_SCALAR];
        2'd1: begin
          if (BW_IDX'(j) <= r_row_m1) begin
            w_rdata[j*BW_SCALAR +: BW_SCALAR] = r_buf[j][int'(r_out_cnt)*BW_SCALAR +: BW_SCALAR];
          end else begin
            w_rdata[j*BW_SCALAR +: BW_SCALAR] = '0;
          end
        end
        2'd2: w_rdata[j*BW_SCALAR +: BW_SCALAR] = r_buf[r_row_m1 - r_out_cnt][j*BW_SCALAR +: BW_SCALAR];
        2'd3: begin
          if (BW_IDX'(j) <= r_col_m1) begin
            w_rdata[j*BW_SCALAR +: BW_SCALAR] =
              r_buf[r_out_cnt][(int'(r_col_m1) - j)*BW_SCALAR +: BW_SCALAR];
          end else begin
            w_rdata[j*BW_SCALAR +: BW_SCALAR] = '0;
          end
        end
        default: w_rdata[j*BW_SCALAR +: BW_SCALAR] = '0;
      endcase
    end
  end

  // Control FSM, matrix buffer and status registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state        <= S_IDLE;
      r_mode         <= 2'd0;
      r_row_m1       <= '0;
      r_col_m1       <= '0;
      r_row_cnt      <= '0;
      r_out_cnt      <= '0;
      r_size_error   <= 1'b0;
      r_clear_finish <= 1'b0;
      for (int r = 0; r < N; r++) begin
        r_buf[r] <= '0;
      end
    end else begin
      r_clear_finish <= bus.clear_request;
      if (bus.clear_request) begin
        r_state      <= S_IDLE;
        r_row_cnt    <= '0;
        r_out_cnt    <= '0;
        r_size_error <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_mode       <= w_inst_mode;
              r_row_m1     <= w_inst_row_m1;
              r_col_m1     <= w_inst_col_m1;
              r_row_cnt    <= '0;
              r_out_cnt    <= '0;
              r_size_error <= 1'b0;
              r_state      <= S_LOAD;
              for (int r = 0; r < N; r++) begin
                r_buf[r] <= '0;
              end
            end
          end
          S_LOAD: begin
            if (bus.sload_row_wvalid) begin
              r_buf[r_row_cnt] <= w_load_row;
              r_row_cnt        <= r_row_cnt + BW_IDX'(1);
              // wlast and the row count must agree, otherwise the matrix size was wrong
              if (bus.sload_row_wlast || w_row_last) begin
                r_state <= S_STORE;
                if (bus.sload_row_wlast != w_row_last) begin
                  r_size_error <= 1'b1;
                end
              end
            end
          end
          S_STORE: begin
            if (bus.sstore_row_rvalid) begin
              r_out_cnt <= r_out_cnt + BW_IDX'(1);
              if (r_out_cnt == w_or_m1) begin
                r_state <= S_DONE;
              end
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dca_matrix_reorder_unit_multimode.sv
// Randomised self-checking bench for the matrix reorder unit (N=4, 8-bit scalars)
// against an array-based model of the four reorder modes.
module tb_dca_matrix_reorder_unit_multimode;
  localparam int N  = 4;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rstnn = 1'b0;
  always #5 clk = ~clk;

  dca_matrix_reorder_unit_multimode_if #(.MATRIX_SIZE(N), .BW_SCALAR(BW)) bus ();
  dca_matrix_reorder_unit_multimode #(.MATRIX_SIZE(N), .BW_SCALAR(BW)) dut (
    .clk(clk), .rstnn(rstnn), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [N*BW-1:0] stim [0:N+1];
  logic [N*BW-1:0] got  [0:15];
  int n_got;
  int n_acc;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected output row i from the matrix as the LSU delivered it
  function automatic logic [N*BW-1:0] model_row(int mode, int rr, int cc, int acc, int i);
    logic [BW-1:0] m [0:N-1][0:N-1];
    logic [N*BW-1:0] row;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++)
        m[r][j] = (r < acc && j < cc) ? stim[r][j*BW +: BW] : '0;
    row = '0;
    for (int j = 0; j < N; j++) begin
      case (mode)
        0: row[j*BW +: BW] = m[i][j];
        1: row[j*BW +: BW] = (j < rr) ? m[j][i] : '0;
        2: row[j*BW +: BW] = m[rr-1-i][j];
        default: row[j*BW +: BW] = (j < cc) ? m[i][cc-1-j] : '0;
      endcase
    end
    return row;
  endfunction

  task automatic set_copy_data();
    stim[0] = 32'h04030201; stim[1] = 32'h08070605;
    stim[2] = 32'h0C0B0A09; stim[3] = 32'h100F0E0D;
    stim[4] = 32'hDEADBEEF; stim[5] = 32'hCAFEF00D;
  endtask

  task automatic issue_and_load(input int mode, input int r_m1, input int c_m1, input int wl_idx);
    int acc_exp;
    acc_exp = (wl_idx < r_m1 + 1) ? wl_idx + 1 : r_m1 + 1;
    @(negedge clk);
    bus.inst_fifo_rready = 1'b1;
    bus.inst_fifo_rdata  = {2'(mode), 2'(r_m1), 2'(c_m1)};
    #1;
    n_tests++;
    if (bus.inst_fifo_rrequest !== 1'b1) begin
      n_fail++; $display("FAIL pop_strobe: got %b expected 1", bus.inst_fifo_rrequest);
    end
    n_acc = 0;
    for (int k = 0; k < N + 2; k++) begin
      @(negedge clk);
      bus.inst_fifo_rready = 1'b0;
      bus.sload_row_wvalid = 1'b1;
      bus.sload_row_wlast  = (k == wl_idx);
      bus.sload_row_wdata  = stim[k];
      #1;
      if (k == 0) begin
        n_tests++;
        if (bus.core_status !== 4'b0101) begin
          n_fail++; $display("FAIL load_status: got %b expected 0101", bus.core_status);
        end
      end
      if (!bus.sload_row_wready) break;
      n_acc++;
    end
    bus.sload_row_wvalid = 1'b0;
    bus.sload_row_wlast  = 1'b0;
    n_tests++;
    if (n_acc != acc_exp) begin
      n_fail++; $display("FAIL rows_accepted: got %0d expected %0d", n_acc, acc_exp);
    end
  endtask

  task automatic store_rows(input int n_out, input int limit, input int bp);
    int cyc;
    logic rv;
    n_got = 0;
    cyc = 0;
    while (n_got < limit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rv = (bp == 0) ? 1'b1 : (bp == 1) ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
      bus.sstore_row_rvalid = rv;
      bus.sstore_row_rlast  = rv && (n_got == n_out - 1);
      #1;
      n_tests++;
      if (bus.sstore_row_rready !== rv) begin
        n_fail++; $display("FAIL rready_tracks_rvalid: got %b expected %b (row %0d)", bus.sstore_row_rready, rv, n_got);
      end
      if (rv && bus.sstore_row_rready) begin
        got[n_got] = bus.sstore_row_rdata;
        n_got++;
      end
    end
    n_tests++;
    if (n_got != limit) begin
      n_fail++; $display("FAIL store_rows_timeout: got %0d expected %0d", n_got, limit);
    end
  endtask

  task automatic run_op(input int mode, input int r_m1, input int c_m1, input int wl_idx, input int bp);
    int n_out;
    logic err;
    logic [N*BW-1:0] exp_row;
    n_out = (mode == 1) ? c_m1 + 1 : r_m1 + 1;
    err   = (wl_idx != r_m1);
    issue_and_load(mode, r_m1, c_m1, wl_idx);
    store_rows(n_out, n_out, bp);
    @(negedge clk);
    bus.sstore_row_rvalid = 1'b1;
    bus.sstore_row_rlast  = 1'b0;
    #1;
    n_tests++;
    if (bus.sstore_row_rready !== 1'b0) begin
      n_fail++; $display("FAIL extra_row_refused: got %b expected 0", bus.sstore_row_rready);
    end
    n_tests++;
    if (bus.operation_finish !== 1'b1) begin
      n_fail++; $display("FAIL finish_pulse: got %b expected 1", bus.operation_finish);
    end
    n_tests++;
    if (bus.core_status !== {err, 3'b111}) begin
      n_fail++; $display("FAIL done_status: got %b expected %b", bus.core_status, {err, 3'b111});
    end
    @(negedge clk);
    bus.sstore_row_rvalid = 1'b0;
    #1;
    n_tests++;
    if (bus.operation_finish !== 1'b0 || bus.core_status !== {err, 3'b000}) begin
      n_fail++; $display("FAIL idle_after_done: got finish %b status %b expected 0 %b",
                         bus.operation_finish, bus.core_status, {err, 3'b000});
    end
    for (int i = 0; i < n_out; i++) begin
      exp_row = model_row(mode, r_m1 + 1, c_m1 + 1, n_acc, i);
      n_tests++;
      if (got[i] !== exp_row) begin
        n_fail++; $display("FAIL row_data m%0d r%0d: got %h expected %h", mode, i, got[i], exp_row);
      end
    end
  endtask

  task automatic test_reset();
    bus.clear_request = 1'b0; bus.inst_fifo_rready = 1'b0; bus.inst_fifo_rdata = '0;
    bus.sload_row_wvalid = 1'b1; bus.sload_row_wlast = 1'b0; bus.sload_row_wdata = '0;
    bus.sstore_row_rvalid = 1'b1; bus.sstore_row_rlast = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({bus.core_status, bus.sload_row_wready, bus.sstore_row_rready, bus.operation_finish,
         bus.clear_finish, bus.inst_fifo_rrequest} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got status %b wready %b rready %b fin %b clr %b pop %b expected all 0",
        bus.core_status, bus.sload_row_wready, bus.sstore_row_rready, bus.operation_finish,
        bus.clear_finish, bus.inst_fifo_rrequest);
    end
    n_tests++;
    if (bus.sstore_row_rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.sstore_row_rdata);
    end
    @(negedge clk);
    bus.sload_row_wvalid = 1'b0; bus.sstore_row_rvalid = 1'b0;
    rstnn = 1'b1;
  endtask

  task automatic test_copy();
    set_copy_data();
    run_op(0, 3, 3, 3, 0);
    n_tests++;
    if (got[0] !== 32'h04030201 || got[3] !== 32'h100F0E0D) begin
      n_fail++; $display("FAIL copy_rows: got %h %h expected 04030201 100f0e0d", got[0], got[3]);
    end
  endtask

  task automatic test_transpose();
    stim[0] = 32'h00030201; stim[1] = 32'h00060504; stim[2] = 32'h11111111;
    run_op(1, 1, 2, 1, 0);
    n_tests++;
    if (got[0] !== 32'h00000401 || got[1] !== 32'h00000502 || got[2] !== 32'h00000603) begin
      n_fail++; $display("FAIL transpose_rows: got %h %h %h expected 00000401 00000502 00000603",
                         got[0], got[1], got[2]);
    end
  endtask

  task automatic test_reverse();
    set_copy_data();
    run_op(2, 3, 3, 3, 0);
    n_tests++;
    if (got[0] !== 32'h100F0E0D || got[3] !== 32'h04030201) begin
      n_fail++; $display("FAIL row_reverse: got %h %h expected 100f0e0d 04030201", got[0], got[3]);
    end
    run_op(3, 3, 3, 3, 0);
    n_tests++;
    if (got[0] !== 32'h01020304) begin
      n_fail++; $display("FAIL col_reverse: got %h expected 01020304", got[0]);
    end
  endtask

  task automatic test_size_error();
    set_copy_data();
    run_op(0, 3, 3, 1, 0);
    n_tests++;
    if (got[1] !== 32'h08070605 || got[2] !== 32'h0 || got[3] !== 32'h0) begin
      n_fail++; $display("FAIL early_wlast_rows: got %h %h %h expected 08070605 0 0", got[1], got[2], got[3]);
    end
    run_op(0, 2, 3, 99, 0);
  endtask

  task automatic test_backpressure();
    set_copy_data();
    run_op(0, 3, 3, 3, 1);
    run_op(3, 3, 2, 3, 2);
  endtask

  task automatic test_clear();
    set_copy_data();
    issue_and_load(0, 3, 3, 3);
    store_rows(4, 1, 0);
    n_tests++;
    if (got[0] !== 32'h04030201) begin
      n_fail++; $display("FAIL clear_first_row: got %h expected 04030201", got[0]);
    end
    @(negedge clk);
    bus.sstore_row_rvalid = 1'b0; bus.clear_request = 1'b1;
    bus.inst_fifo_rready = 1'b1; bus.inst_fifo_rdata = 6'b001111;
    #1;
    n_tests++;
    if (bus.inst_fifo_rrequest !== 1'b0 || bus.operation_finish !== 1'b0) begin
      n_fail++; $display("FAIL clear_store_cycle: got pop %b fin %b expected 0 0", bus.inst_fifo_rrequest, bus.operation_finish);
    end
    @(negedge clk);
    bus.clear_request = 1'b0; bus.inst_fifo_rready = 1'b0;
    #1;
    n_tests++;
    if (bus.core_status !== 4'b0000 || bus.clear_finish !== 1'b1 || bus.operation_finish !== 1'b0) begin
      n_fail++; $display("FAIL clear_ack: got status %b clr %b fin %b expected 0000 1 0",
                         bus.core_status, bus.clear_finish, bus.operation_finish);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.clear_finish !== 1'b0 || bus.operation_finish !== 1'b0) begin
      n_fail++; $display("FAIL clear_pulse_width: got clr %b fin %b expected 0 0", bus.clear_finish, bus.operation_finish);
    end
    @(negedge clk);
    bus.clear_request = 1'b1; bus.inst_fifo_rready = 1'b1;
    #1;
    n_tests++;
    if (bus.inst_fifo_rrequest !== 1'b0) begin
      n_fail++; $display("FAIL clear_blocks_pop: got %b expected 0", bus.inst_fifo_rrequest);
    end
    @(negedge clk);
    bus.clear_request = 1'b0; bus.inst_fifo_rready = 1'b0;
    #1;
    n_tests++;
    if (bus.core_status !== 4'b0000 || bus.clear_finish !== 1'b1) begin
      n_fail++; $display("FAIL clear_in_idle: got status %b clr %b expected 0000 1", bus.core_status, bus.clear_finish);
    end
    run_op(0, 3, 3, 3, 0);
    n_tests++;
    if (got[2] !== 32'h0C0B0A09) begin
      n_fail++; $display("FAIL after_clear_row: got %h expected 0c0b0a09", got[2]);
    end
  endtask

  task automatic test_back_to_back();
    int mode, r_m1, c_m1, wl, sel;
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < N + 2; k++) stim[k] = $urandom;
      mode = $urandom_range(0, 3);
      r_m1 = $urandom_range(0, 3);
      c_m1 = $urandom_range(0, 3);
      sel  = $urandom_range(0, 3);
      wl   = (sel == 0) ? 99 : (sel == 1) ? $urandom_range(0, r_m1) : r_m1;
      run_op(mode, r_m1, c_m1, wl, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_transpose();
    test_reverse();
    test_size_error();
    test_backpressure();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
